// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-way data-RAM arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int REQ_CPU       = 0;
    localparam int REQ_LDR       = 1;
    localparam int BURST_MAX_DEF = 4;
    localparam int CNT_W         = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: the current owner keeps priority while it
// still requests; otherwise a lone request wins and a tie goes to ~last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] owner,
    output logic [1:0] win
);

    always_comb begin
        // NOTE: default assignment first so no path through the block infers a latch.
        win = 2'b00;
        if (owner[0] && req[0]) begin
            win = 2'b01;
        end else if (owner[1] && req[1]) begin
            win = 2'b10;
        end else begin
            case (req)
                2'b01:   win = 2'b01;
                2'b10:   win = 2'b10;
                2'b11:   win = last ? 2'b01 : 2'b10;
                default: win = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data RAM between the CPU and the
// loader, with short locked bursts. Optional macro: DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int WIDTH     = 32,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic             lock0,
    input  logic             lock1,
    input  logic [BITS-1:0]  addr0,
    input  logic [BITS-1:0]  addr1,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic             err0,
    output logic             err1,
    output logic             ram_we,
    output logic [BITS-1:0]  ram_addr,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout
);

    localparam logic [CNT_W:0] BURST_LIM = (CNT_W + 1)'(BURST_MAX);

    arb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic [1:0]       win;
    logic [1:0]       gnt;
    logic             granted;
    logic             sel;
    logic             sel_we;
    logic             sel_lock;
    logic             blocked;
    logic [CNT_W:0]   cnt_inc;

    rr_pick2 u_pick (
        .req   ({req1, req0}),
        .last  (last),
        .owner ({state == OWN1, state == OWN0}),
        .win   (win)
    );

    // Grants are suppressed while reset is asserted, independent of the picker.
    assign gnt      = rst_n ? win : 2'b00;
    assign gnt0     = gnt[REQ_CPU];
    assign gnt1     = gnt[REQ_LDR];
    assign granted  = |gnt;
    assign sel      = gnt[REQ_LDR];
    assign sel_we   = sel ? we1 : we0;
    assign sel_lock = sel ? lock1 : lock0;
    assign ram_addr = sel ? addr1 : addr0;
    assign ram_din  = sel ? din1 : din0;
    assign cnt_inc  = {1'b0, cnt} + 1'b1;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign blocked = granted && (ram_addr[1:0] != 2'b00);
`else
    assign blocked = 1'b0;
`endif

    assign ram_we = granted && sel_we && !blocked;

    // NOTE: all state below uses non-blocking assignments; only control/response
    // registers are reset, the RAM contents live outside and are never cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            rdata0  <= '0;
            rdata1  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            err0    <= 1'b0;
            err1    <= 1'b0;
        end else begin
            rvalid0 <= gnt[REQ_CPU] && !we0;
            rvalid1 <= gnt[REQ_LDR] && !we1;
            err0    <= gnt[REQ_CPU] && blocked;
            err1    <= gnt[REQ_LDR] && blocked;

            if (gnt[REQ_CPU] && !we0) rdata0 <= blocked ? '0 : ram_dout;
            if (gnt[REQ_LDR] && !we1) rdata1 <= blocked ? '0 : ram_dout;

            if (granted) begin
                last <= sel;
                // The counter counts grants already taken in this burst.
                if (sel_lock && (cnt_inc < BURST_LIM)) begin
                    state <= sel ? OWN1 : OWN0;
                    cnt   <= cnt_inc[CNT_W-1:0];
                end else begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            end else begin
                state <= IDLE;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural RAM; inputs change
// on the falling edge, combinational outputs are checked 1 ns later.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, din0, din1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        ram_we;
    logic [31:0] ram_addr, ram_din, ram_dout;

    logic [31:0] mem [0:63];
    int          tests = 0;
    int          fails = 0;
    int          i0, i1;

    always #5 clk = ~clk;

    assign ram_dout = mem[ram_addr[7:2]];
    always @(posedge clk) if (ram_we) mem[ram_addr[7:2]] <= ram_din;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .din0(din0), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .err0(err0), .err1(err1),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0101_0101 * 32'(i);
        mem[1] = 32'h0101_0101;
        mem[4] = 32'hDEAD_BEEF;
        mem[5] = 32'hCAFE_F00D;
        mem[8] = 32'h1111_2222;

        // Reset held with both requesters asking.
        rst_n = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        lock0 = 1'b0; lock1 = 1'b0;
        addr0 = 32'h10; addr1 = 32'h20; din0 = '0; din1 = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt0", {31'b0, gnt0}, 32'd0);
        check("rst_gnt1", {31'b0, gnt1}, 32'd0);
        check("rst_ram_we", {31'b0, ram_we}, 32'd0);
        check("rst_rvalid0", {31'b0, rvalid0}, 32'd0);
        check("rst_rvalid1", {31'b0, rvalid1}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);

        // First tie after release goes to requester 0 (read of word 4).
        rst_n = 1'b1;
        #1;
        check("tie_gnt0", {31'b0, gnt0}, 32'd1);
        check("tie_gnt1", {31'b0, gnt1}, 32'd0);
        check("tie_ram_addr", ram_addr, 32'h10);

        @(negedge clk);
        check("rd0_rvalid", {31'b0, rvalid0}, 32'd1);
        check("rd0_rdata", rdata0, 32'hDEAD_BEEF);
        check("rd0_rvalid1", {31'b0, rvalid1}, 32'd0);
        req0 = 1'b0;
        #1;
        check("rd1_gnt1", {31'b0, gnt1}, 32'd1);

        // Single read by requester 0 of word 5.
        @(negedge clk);
        check("rd1_rvalid", {31'b0, rvalid1}, 32'd1);
        check("rd1_rdata", rdata1, 32'h1111_2222);
        req1 = 1'b0; req0 = 1'b1; addr0 = 32'h14;
        #1;
        check("single_gnt0", {31'b0, gnt0}, 32'd1);
        @(negedge clk);
        check("single_rvalid0", {31'b0, rvalid0}, 32'd1);
        check("single_rdata0", rdata0, 32'hCAFE_F00D);
        check("rdata1_held", rdata1, 32'h1111_2222);
        // Requester 1 alone so that last = 1 before contention.
        req0 = 1'b0; req1 = 1'b1; addr1 = 32'h20;
        #1;
        check("solo_gnt1", {31'b0, gnt1}, 32'd1);
        @(negedge clk);
        check("single_rvalid0_drop", {31'b0, rvalid0}, 32'd0);

        // Alternating writes, no lock: 0,1,0,1,0,1.
        i0 = 0; i1 = 0;
        for (int k = 0; k < 6; k++) begin
            if (k != 0) @(negedge clk);
            req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40 + 32'(4 * i0); din0 = 32'hA0 + 32'(i0);
            req1 = 1'b1; we1 = 1'b1; addr1 = 32'h80 + 32'(4 * i1); din1 = 32'hB0 + 32'(i1);
            #1;
            check("alt_gnt0", {31'b0, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check("alt_gnt1", {31'b0, gnt1}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check("alt_ram_we", {31'b0, ram_we}, 32'd1);
            if (gnt0) i0++;
            if (gnt1) i1++;
        end
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        check("alt_mem16", mem[16], 32'hA0);
        check("alt_mem17", mem[17], 32'hA1);
        check("alt_mem18", mem[18], 32'hA2);
        check("alt_mem32", mem[32], 32'hB0);
        check("alt_mem33", mem[33], 32'hB1);
        check("alt_mem34", mem[34], 32'hB2);

        // Locked burst by requester 1, requester 0 waiting from the second cycle.
        @(negedge clk);
        req1 = 1'b1; lock1 = 1'b1; addr1 = 32'h20;
        #1;
        check("burst_gnt1_0", {31'b0, gnt1}, 32'd1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            req0 = 1'b1; addr0 = 32'h10;
            #1;
            check("burst_gnt1", {31'b0, gnt1}, 32'd1);
            check("burst_gnt0", {31'b0, gnt0}, 32'd0);
        end
        @(negedge clk);
        check("burst_rvalid1", {31'b0, rvalid1}, 32'd1);
        #1;
        check("burst_end_gnt0", {31'b0, gnt0}, 32'd1);
        check("burst_end_gnt1", {31'b0, gnt1}, 32'd0);
        @(negedge clk);
        #1;
        check("regain_gnt1", {31'b0, gnt1}, 32'd1);
        @(negedge clk);
        #1;
        check("regain2_gnt1", {31'b0, gnt1}, 32'd1);

        // Reset pulse in the middle of the new burst.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_gnt0", {31'b0, gnt0}, 32'd0);
        check("midrst_gnt1", {31'b0, gnt1}, 32'd0);
        check("midrst_rvalid1", {31'b0, rvalid1}, 32'd0);
        check("midrst_ram_we", {31'b0, ram_we}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("postrst_gnt0", {31'b0, gnt0}, 32'd1);
        check("postrst_gnt1", {31'b0, gnt1}, 32'd0);

        // Unaligned write to byte address 6 (word 1).
        @(negedge clk);
        req1 = 1'b0; lock1 = 1'b0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h6; din0 = 32'h55;
        #1;
        check("unal_gnt0", {31'b0, gnt0}, 32'd1);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        check("unal_ram_we", {31'b0, ram_we}, 32'd0);
`else
        check("unal_ram_we", {31'b0, ram_we}, 32'd1);
`endif
        @(negedge clk);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        check("unal_err0", {31'b0, err0}, 32'd1);
        check("unal_mem1", mem[1], 32'h0101_0101);
        we0 = 1'b0;
        #1;
        check("unal_rd_gnt0", {31'b0, gnt0}, 32'd1);
        @(negedge clk);
        check("unal_rd_err0", {31'b0, err0}, 32'd1);
        check("unal_rd_rvalid0", {31'b0, rvalid0}, 32'd1);
        check("unal_rd_rdata0", rdata0, 32'd0);
`else
        check("unal_err0", {31'b0, err0}, 32'd0);
        check("unal_mem1", mem[1], 32'h55);
`endif
        req0 = 1'b0;
        @(negedge clk);
        check("idle_err0", {31'b0, err0}, 32'd0);
        check("idle_gnt0", {31'b0, gnt0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
